ser_stream: RTL and testbench

Parametrised serializer: accepts parallel words of up to `DATA_W` bits with a per-word bit count and bit-order mode, then emits them one bit per clock on a serial output with valid and last markers. A one-word holding register lets consecutive words stream back-to-back with no idle cycle between them. It is the successor to the fixed 16-bit serializer and sits between the parallel data source and the serial line driver.

---
 rtl/ser_stream_pkg.sv | 17 +
 rtl/ser_bit_counter.sv | 36 +++
 rtl/ser_stream.sv | 104 ++++++++++
 tb/tb_ser_stream.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_stream_pkg.sv
// Shared types and helpers for the ser_stream serializer.
// The slot struct depends on DATA_W, so it is declared inside ser_stream itself.
package ser_stream_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_VALID = 1'b1
    } slot_state_e;

    localparam int MIN_DATA_W = 2;

    // Requested bit counts above the word width send the whole word.
    function automatic int clamp_mod(input int mod, input int data_w);
        return (mod > data_w) ? data_w : mod;
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter that tracks the bits remaining in the active word.
module ser_bit_counter #(
    parameter int MOD_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [MOD_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o,
    output logic             zero_o
);

    logic [MOD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - MOD_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == MOD_W'(1));
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ser_stream.sv
// Parallel-to-serial converter with one active and one pending word slot.
// The active slot is valid exactly when its bit counter is non-zero.
module ser_stream
    import ser_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_val_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              lsb_first_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_last_o,
    output logic              busy_o
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [MOD_W-1:0]  cnt;
        logic              lsb_first;
    } slot_t;

    slot_t             pend_q, pend_d;
    slot_state_e       pend_state_q, pend_state_d;
    logic [DATA_W-1:0] act_sh_q, act_sh_d;
    logic              act_lsb_q, act_lsb_d;

    logic              cnt_load, cnt_dec, cnt_last, cnt_zero;
    logic [MOD_W-1:0]  cnt_load_val;
    logic [MOD_W-1:0]  in_n;
    logic              act_valid, act_free, in_go;

    ser_bit_counter #(.MOD_W(MOD_W)) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last),
        .zero_o     (cnt_zero)
    );

    assign busy_o    = (pend_state_q == SLOT_VALID);
    assign act_valid = !cnt_zero;
    assign act_free  = cnt_zero || cnt_last;
    assign in_n      = MOD_W'(clamp_mod(int'(data_mod_i), DATA_W));
    // Zero-length words are accepted but never occupy a slot.
    assign in_go     = data_val_i && !busy_o && (in_n != '0);

    always_comb begin
        pend_d       = pend_q;
        pend_state_d = pend_state_q;
        act_sh_d     = act_sh_q;
        act_lsb_d    = act_lsb_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = act_valid;

        if (act_valid) begin
            act_sh_d = act_lsb_q ? (act_sh_q >> 1) : (act_sh_q << 1);
        end

        if (act_free) begin
            if (pend_state_q == SLOT_VALID) begin
                act_sh_d     = pend_q.data;
                act_lsb_d    = pend_q.lsb_first;
                cnt_load     = 1'b1;
                cnt_load_val = pend_q.cnt;
                pend_state_d = SLOT_EMPTY;
            end else if (in_go) begin
                act_sh_d     = data_i;
                act_lsb_d    = lsb_first_i;
                cnt_load     = 1'b1;
                cnt_load_val = in_n;
            end
        end else if (in_go) begin
            pend_d       = '{data: data_i, cnt: in_n, lsb_first: lsb_first_i};
            pend_state_d = SLOT_VALID;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q       <= '0;
            pend_state_q <= SLOT_EMPTY;
            act_sh_q     <= '0;
            act_lsb_q    <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_state_q <= pend_state_d;
            act_sh_q     <= act_sh_d;
            act_lsb_q    <= act_lsb_d;
        end
    end

    assign ser_data_val_o = act_valid;
    assign ser_last_o     = act_valid && cnt_last;
    assign ser_data_o     = act_valid && (act_lsb_q ? act_sh_q[0] : act_sh_q[DATA_W-1]);

endmodule

// File: tb/tb_ser_stream.sv
// Directed bench for ser_stream: a bit-queue reference model checked every cycle,
// plus literal expectations on the observed serial stream of each scenario.
module tb_ser_stream;

    localparam int DATA_W = 16;
    localparam int MOD_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              data_val;
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  mod;
    logic              lsb;
    logic              ser_data, ser_val, ser_last, busy;

    ser_stream #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_val_i     (data_val),
        .data_i         (data),
        .data_mod_i     (mod),
        .lsb_first_i    (lsb),
        .ser_data_o     (ser_data),
        .ser_data_val_o (ser_val),
        .ser_last_o     (ser_last),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: every accepted word becomes a run of {bit,last} entries in
    // one queue; one entry leaves per clock. Busy = a second whole word is queued.
    bit q_bit[$];
    bit q_last[$];
    bit m_busy  = 1'b0;
    bit started = 1'b0;

    always @(posedge clk) begin : model
        int n;
        int words;
        started = 1'b1;
        if (rst) begin
            q_bit.delete();
            q_last.delete();
        end else begin
            bit acc;
            acc = data_val && !m_busy;
            if (q_bit.size() > 0) begin
                void'(q_bit.pop_front());
                void'(q_last.pop_front());
            end
            if (acc) begin
                n = (int'(mod) > DATA_W) ? DATA_W : int'(mod);
                for (int i = 0; i < n; i++) begin
                    q_bit.push_back(lsb ? data[i] : data[DATA_W-1-i]);
                    q_last.push_back(i == n - 1);
                end
            end
        end
        words = 0;
        foreach (q_last[i]) if (q_last[i]) words++;
        m_busy = (words >= 2);
    end

    logic [63:0] obs_bits;
    int obs_cnt, obs_lasts, run, max_run, busy_hi;

    always @(negedge clk) begin : compare
        bit ev;
        if (started) begin
            ev = (q_bit.size() > 0);
            check("ser_val",  ser_val,  ev);
            check("ser_data", ser_data, ev ? q_bit[0] : 1'b0);
            check("ser_last", ser_last, ev ? q_last[0] : 1'b0);
            check("busy",     busy,     m_busy);
            if (ser_val) begin
                obs_bits = {obs_bits[62:0], ser_data};
                obs_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (ser_last) obs_lasts++;
            if (busy) busy_hi++;
        end
    end

    task automatic clear_obs();
        obs_bits = '0; obs_cnt = 0; obs_lasts = 0; run = 0; max_run = 0; busy_hi = 0;
    endtask

    task automatic expect_seq(input string nm, input int cnt, input logic [63:0] bits);
        check({nm, "_cnt"}, 64'(obs_cnt), 64'(cnt));
        check({nm, "_bits"}, obs_bits, bits);
    endtask

    // Called just after a rising edge; returns just after the edge that accepts.
    task automatic send(input logic [15:0] d, input logic [4:0] m, input logic l);
        int t = 0;
        data_val = 1'b1; data = d; mod = m; lsb = l;
        while (m_busy && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (m_busy) check("send_timeout", 64'(t), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        data_val = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clear_obs();
        rst = 1'b1; data_val = 1'b1; data = 16'hA5F0; mod = 5'd4; lsb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_val",  ser_val, 1'b0);
        check("rst_busy", busy,    1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_nothing", 64'(obs_cnt), 64'(0));

        clear_obs();
        send(16'hA5F0, 5'd4, 1'b0);
        idle(6);
        expect_seq("msb", 4, 64'b1010);
        check("msb_lasts", 64'(obs_lasts), 64'(1));

        clear_obs();
        send(16'hA5F3, 5'd4, 1'b1);
        idle(6);
        expect_seq("lsb", 4, 64'b1100);

        clear_obs();
        send(16'hFFFF, 5'd3, 1'b0);
        send(16'h0000, 5'd2, 1'b0);
        send(16'hFFFF, 5'd3, 1'b0);
        idle(10);
        expect_seq("b2b", 8, 64'b11100111);
        check("b2b_run",   64'(max_run), 64'(8));
        check("b2b_busy",  64'(busy_hi), 64'(3));
        check("b2b_lasts", 64'(obs_lasts), 64'(3));

        clear_obs();
        send(16'h0001, 5'd1, 1'b1);
        send(16'h0000, 5'd1, 1'b1);
        send(16'h0001, 5'd1, 1'b1);
        idle(5);
        expect_seq("n1", 3, 64'b101);
        check("n1_run", 64'(max_run), 64'(3));

        clear_obs();
        send(16'h1234, 5'd0, 1'b0);
        idle(4);
        expect_seq("mod0", 0, 64'h0);
        check("mod0_busy", 64'(busy_hi), 64'(0));

        clear_obs();
        send(16'h1234, 5'd31, 1'b0);
        idle(20);
        expect_seq("mod31", 16, 64'h1234);
        check("mod31_lasts", 64'(obs_lasts), 64'(1));

        clear_obs();
        send(16'hBEEF, 5'd16, 1'b0);
        send(16'h1234, 5'd4, 1'b1);
        data_val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_val",  ser_val,  1'b0);
        check("midrst_data", ser_data, 1'b0);
        check("midrst_last", ser_last, 1'b0);
        check("midrst_busy", busy,     1'b0);
        expect_seq("midrst_pre", 3, 64'b101);
        @(posedge clk); #1;

        clear_obs();
        send(16'h0013, 5'd5, 1'b1);
        idle(10);
        expect_seq("after_rst", 5, 64'b11001);
        check("after_rst_lasts", 64'(obs_lasts), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule
